rhs_headstage_emulator_array: RTL and testbench
===============================================

Name: rhs_headstage_emulator_array

Overview:
- Parametrised emulator of N_PORTS RHS-class stimulation/recording headstages sharing one SPI bus (MOSI, CS, SCLK), with one MISO output per port.
- Used in controller-side simulation and hardware loopback benches to exercise the SPI master, cable-delay calibration and data capture without real silicon.
- Adds the following over the fixed 16-port model:
  - configurable port count and seed spacing;
  - a real 32-bit command decoder with the RHS two-frame response pipeline;
  - ROM and chip-ID reads;
  - per-port programmable cable delay;
  - frame-error reporting.

Parameters:
- N_PORTS, 16: number of emulated headstages / MISO lines (1..32).
- STARTING_SEED, 2048: LFSR seed of port 0.
- SEED_STRIDE, 16: seed increment per port. Port i seed = STARTING_SEED + i*SEED_STRIDE, truncated to 16 bits; a resulting zero is forced to 16'h0001.
- MAX_DELAY, 15: maximum MISO delay in clk cycles.
- DELAY_W, 4: width of each per-port delay field; must satisfy 2^DELAY_W-1 >= MAX_DELAY.
- CHIP_ID, 16'h0020: value returned for a READ of register 255.

Ports:
- clk  in  1  system clock; must run at 4x SCLK or faster.
- rst  in  1  asynchronous, active-high reset.
- MOSI  in  1  SPI data from master; asynchronous to clk.
- CS  in  1  SPI chip select, active low; asynchronous.
- SCLK  in  1  SPI clock, idle low; asynchronous.
- cable_delay  in  N_PORTS*DELAY_W  per-port MISO delay in clk cycles. Port i occupies bits [i*DELAY_W +: DELAY_W]; values above MAX_DELAY clamp to MAX_DELAY.
- MISO  out  N_PORTS  per-port SPI response data.
- frame_err  out  1  one-clk pulse when a frame ends with a bit count other than 32.
- frame_count  out  16  number of completed frames, good or bad; wraps modulo 2^16.

Behaviour:
- Synchronisers and edge detection:
  - MOSI, CS and SCLK each pass through a 2-flop synchroniser.
  - SCLK rise/fall and CS fall/rise are detected on the synchronised signals.
  - Input-to-action latency is 3 clk cycles.
- Reset (asynchronous):
  - MISO=0, frame_err=0, frame_count=0.
  - FSM in IDLE.
  - Response pipeline cleared to 0.
  - All LFSRs reloaded with their seeds.
- FSM states: IDLE, SHIFT, DECODE.
  - IDLE -> SHIFT on CS fall. At that point:
    - bit counter = 0;
    - cable_delay is latched for the whole frame;
    - each port's tx shifter loads its response word, and bit 31 drives the delay line.
  - SHIFT:
    - On SCLK rise: sample MOSI into the rx shifter (MSB first) and increment the bit counter, saturating at 33.
    - On SCLK fall: shift the tx shifter left by one bit.
    - On CS rise: go to DECODE.
  - DECODE (one cycle), then return to IDLE:
    - frame_count increments.
    - If bit count != 32: frame_err pulses and the command is treated as a NOP (response 0).
    - Otherwise the command is decoded as below.
- Command decode (rx[31:0]):
  - CONVERT, rx[31:30]=00, channel = rx[21:16]: each port's LFSR advances once. Response = {lfsr_next[15:0], 10'b0, channel}.
  - READ, rx[31:30]=11, addr = rx[23:16]:
    - 251 -> 16'h494E;
    - 252 -> 16'h5441;
    - 253 -> 16'h4E00;
    - 255 -> CHIP_ID;
    - any other address -> 0.
    - Response = {16'h0000, value}.
  - WRITE, rx[31:30]=10: response = {16'hFFFF, rx[15:0]}. No state change.
  - rx[31:30]=01: response 0.
- Response pipeline:
  - Two frames deep. The response to the command in frame N is shifted out during frame N+2.
  - The pipeline advances only in DECODE.
- LFSR:
  - 16-bit Galois, polynomial mask 16'hB400.
  - Shift right; when the LSB is 1, XOR with the mask.
  - Advances only on a valid CONVERT.
- MISO:
  - Forced 0 while the synchronised CS is high or the FSM is in IDLE.
  - Otherwise MISO[i] = tx bit 31 of port i, delayed by the latched cable_delay[i] clk cycles through a MAX_DELAY-deep shift line.
  - A delay of 0 gives a combinational tap of the registered tx bit.
- Conflicts and edge cases:
  - CS rise and an SCLK edge in the same cycle: CS wins and the edge is ignored.
  - SCLK edges while CS is high are ignored.
  - A CS glitch shorter than the synchroniser delay is ignored.
  - Reset mid-frame aborts the frame; no DECODE and no frame_count increment.

Decomposition:
- Package rhs_emu_pkg holds:
  - opcode constants (OP_CONVERT, OP_WRITE, OP_READ);
  - ROM addresses and values (251..253, 255);
  - LFSR_POLY;
  - the FSM state enum;
  - the seed function seed_of(i).
- Sub-module rhs_emu_port is instantiated N_PORTS times via generate. It contains the LFSR, response generation, the two-deep response pipeline, the tx shifter and the delay line.
- The top level holds the synchronisers, the FSM, the rx shifter and the bit counter.

Test Plan:
- Reset, then three 32-bit CONVERT frames to channel 5:
  - frames 1–2: MISO all zero;
  - frame 3: port 0 returns {lfsr(2048 advanced once), 16'h0005};
  - port 1 is seeded from 2064.
- READ 251, 252, 253, 255, then two NOP frames: responses arrive two frames later as 16'h494E, 16'h5441, 16'h4E00, 16'h0020.
- WRITE with rx[15:0]=16'hA5C3: two frames later MISO carries 32'hFFFFA5C3 on every port, and the LFSRs do not advance.
- Frame with 31 SCLK pulses:
  - frame_err pulses once and frame_count increments;
  - the response two frames later is 0;
  - the following 33-pulse frame also flags frame_err.
- cable_delay port 2 = 7, others = 0: port 2's MISO waveform equals port 0's shifted by exactly 7 clk cycles. A delay of 20 clamps to 15. Changing the delay mid-frame has no effect until the next CS fall.
- Assert rst mid-frame:
  - MISO goes to 0 immediately;
  - frame_count does not increment;
  - the next CONVERT sequence restarts from the seeds.

Source files
------------

// File: rtl/rhs_emu_pkg.sv
// Shared constants, state type and seed helper for the RHS headstage emulator.
package rhs_emu_pkg;

  localparam logic [1:0] OP_CONVERT = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  localparam logic [7:0] ROM_A0  = 8'd251;
  localparam logic [7:0] ROM_A1  = 8'd252;
  localparam logic [7:0] ROM_A2  = 8'd253;
  localparam logic [7:0] ID_ADDR = 8'd255;

  localparam logic [15:0] ROM_V0 = 16'h494E;
  localparam logic [15:0] ROM_V1 = 16'h5441;
  localparam logic [15:0] ROM_V2 = 16'h4E00;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DECODE
  } state_t;

  // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
  function automatic logic [15:0] seed_of(
    input int i,
    input int start,
    input int stride
  );
    logic [31:0] s;
    s = 32'(start + i * stride);
    return (s[15:0] == 16'h0) ? 16'h0001 : s[15:0];
  endfunction

endpackage

// File: rtl/rhs_headstage_emulator_array_port.sv
// One emulated headstage: LFSR, command response, two-frame pipeline,
// tx shifter and programmable MISO delay line.
module rhs_emu_port
  import rhs_emu_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'h0800,
  parameter int          MAX_DELAY = 15,
  parameter int          DELAY_W   = 4,
  parameter logic [15:0] CHIP_ID   = 16'h0020
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic               i_decode,
  input  logic               i_valid,
  input  logic [31:0]        i_cmd,
  input  logic [DELAY_W-1:0] i_delay,
  output logic               o_miso
);

  logic [15:0]          r_lfsr;
  logic [31:0]          r_pipe0;
  logic [31:0]          r_pipe1;
  logic [31:0]          r_tx;
  logic [MAX_DELAY-1:0] r_line;

  logic [15:0]        w_lfsr_nx;
  logic [15:0]        w_rom;
  logic [31:0]        w_resp;
  logic               w_adv;
  logic [DELAY_W-1:0] w_dly;
  logic               w_tap;

  assign w_lfsr_nx = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : 16'h0);
  assign w_adv = i_decode & i_valid & (i_cmd[31:30] == OP_CONVERT);

  always_comb begin
    w_rom = 16'h0;
    case (i_cmd[23:16])
      ROM_A0:  w_rom = ROM_V0;
      ROM_A1:  w_rom = ROM_V1;
      ROM_A2:  w_rom = ROM_V2;
      ID_ADDR: w_rom = CHIP_ID;
      default: w_rom = 16'h0;
    endcase
  end

  always_comb begin
    w_resp = 32'h0;
    if (i_valid) begin
      case (i_cmd[31:30])
        OP_CONVERT: w_resp = {w_lfsr_nx, 10'b0, i_cmd[21:16]};
        OP_READ:    w_resp = {16'h0000, w_rom};
        OP_WRITE:   w_resp = {16'hFFFF, i_cmd[15:0]};
        default:    w_resp = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr  <= SEED;
      r_pipe0 <= '0;
      r_pipe1 <= '0;
      r_tx    <= '0;
      r_line  <= '0;
    end else begin
      if (w_adv)
        r_lfsr <= w_lfsr_nx;
      if (i_decode) begin
        r_pipe0 <= w_resp;
        r_pipe1 <= r_pipe0;
      end
      if (i_load)
        r_tx <= r_pipe1;
      else if (i_shift)
        r_tx <= {r_tx[30:0], 1'b0};
      r_line[0] <= r_tx[31];
      for (int k = 1; k < MAX_DELAY; k++)
        r_line[k] <= r_line[k-1];
    end
  end

  assign w_dly = (i_delay > DELAY_W'(MAX_DELAY)) ?
                 DELAY_W'(MAX_DELAY) : i_delay;

  // Tap k of the line is the tx MSB delayed by k clk cycles.
  always_comb begin
    w_tap = r_tx[31];
    for (int k = 1; k <= MAX_DELAY; k++)
      if (w_dly == DELAY_W'(k))
        w_tap = r_line[k-1];
  end

  assign o_miso = w_tap;

endmodule

// File: rtl/rhs_headstage_emulator_array.sv
// N-port RHS headstage emulator: SPI synchronisers, frame FSM,
// rx shifter and bit counter shared by all emulated ports.
import rhs_emu_pkg::*;

module rhs_headstage_emulator_array #(
  parameter int          N_PORTS       = 16,
  parameter int          STARTING_SEED = 2048,
  parameter int          SEED_STRIDE   = 16,
  parameter int          MAX_DELAY     = 15,
  parameter int          DELAY_W       = 4,
  parameter logic [15:0] CHIP_ID       = 16'h0020
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         MOSI,
  input  logic                         CS,
  input  logic                         SCLK,
  input  logic [N_PORTS*DELAY_W-1:0]   cable_delay,
  output logic [N_PORTS-1:0]           MISO,
  output logic                         frame_err,
  output logic [15:0]                  frame_count
);

  logic [1:0] r_mosi_s;
  logic [1:0] r_cs_s;
  logic [1:0] r_sclk_s;
  logic       r_cs_d;
  logic       r_sclk_d;

  state_t                       r_state;
  state_t                       w_next;
  logic [31:0]                  r_rx;
  logic [5:0]                   r_bits;
  logic [N_PORTS*DELAY_W-1:0]   r_dly;
  logic [15:0]                  r_fcnt;
  logic                         r_ferr;

  logic               w_cs;
  logic               w_cs_fall;
  logic               w_cs_rise;
  logic               w_sclk_rise;
  logic               w_sclk_fall;
  logic               w_load;
  logic               w_rx_en;
  logic               w_shift;
  logic               w_decode;
  logic               w_valid;
  logic [N_PORTS-1:0] w_miso;

  // Syncs clear to 0 so a CS held low across reset is not seen as a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mosi_s <= '0;
      r_cs_s   <= '0;
      r_sclk_s <= '0;
      r_cs_d   <= 1'b0;
      r_sclk_d <= 1'b0;
    end else begin
      r_mosi_s <= {r_mosi_s[0], MOSI};
      r_cs_s   <= {r_cs_s[0], CS};
      r_sclk_s <= {r_sclk_s[0], SCLK};
      r_cs_d   <= r_cs_s[1];
      r_sclk_d <= r_sclk_s[1];
    end
  end

  assign w_cs        = r_cs_s[1];
  assign w_cs_fall   = r_cs_d & ~w_cs;
  assign w_cs_rise   = ~r_cs_d & w_cs;
  assign w_sclk_rise = ~r_sclk_d & r_sclk_s[1];
  assign w_sclk_fall = r_sclk_d & ~r_sclk_s[1];

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_rx_en  = 1'b0;
    w_shift  = 1'b0;
    w_decode = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_next = SHIFT;
          w_load = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_next = DECODE;
        end else begin
          w_rx_en = w_sclk_rise & ~w_cs;
          w_shift = w_sclk_fall & ~w_cs;
        end
      end
      DECODE: begin
        w_next   = IDLE;
        w_decode = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rx    <= '0;
      r_bits  <= '0;
      r_dly   <= '0;
      r_fcnt  <= '0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_bits <= '0;
        r_dly  <= cable_delay;
      end
      if (w_rx_en) begin
        r_rx <= {r_rx[30:0], r_mosi_s[1]};
        if (r_bits != 6'd33)
          r_bits <= r_bits + 6'd1;
      end
      r_ferr <= w_decode & (r_bits != 6'd32);
      r_fcnt <= r_fcnt + 16'(w_decode);
    end
  end

  assign w_valid = (r_bits == 6'd32);

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    rhs_emu_port #(
      .SEED      (seed_of(g, STARTING_SEED, SEED_STRIDE)),
      .MAX_DELAY (MAX_DELAY),
      .DELAY_W   (DELAY_W),
      .CHIP_ID   (CHIP_ID)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_shift  (w_shift),
      .i_decode (w_decode),
      .i_valid  (w_valid),
      .i_cmd    (r_rx),
      .i_delay  (r_dly[g*DELAY_W +: DELAY_W]),
      .o_miso   (w_miso[g])
    );
  end

  assign MISO        = (w_cs || r_state == IDLE) ? '0 : w_miso;
  assign frame_err   = r_ferr;
  assign frame_count = r_fcnt;

endmodule

// File: tb/tb_rhs_headstage_emulator_array.sv
// Self-checking bench: directed vector table, delay/reset sequences
// and random frames against a behavioural headstage model.
module tb_rhs_headstage_emulator_array;

  localparam int N  = 4;
  localparam int DW = 5;
  localparam int MD = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            MOSI;
  logic            CS;
  logic            SCLK;
  logic [N*DW-1:0] cable_delay;
  logic [N-1:0]    MISO;
  logic            frame_err;
  logic [15:0]     frame_count;

  rhs_headstage_emulator_array #(
    .N_PORTS       (N),
    .STARTING_SEED (2048),
    .SEED_STRIDE   (16),
    .MAX_DELAY     (MD),
    .DELAY_W       (DW),
    .CHIP_ID       (16'h0020)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MOSI        (MOSI),
    .CS          (CS),
    .SCLK        (SCLK),
    .cable_delay (cable_delay),
    .MISO        (MISO),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int errpulses = 0;
  int fr_err;
  int nck;
  logic [31:0] cap [N];

  bit      rec_on = 1'b0;
  int      chg_at = 0;
  logic [DW-1:0] chg_val;
  logic    tr0 [$];
  logic    tr2 [$];

  always @(posedge clk)
    if (frame_err === 1'b1)
      errpulses++;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    nck++;
    if (rec_on && nck > 6 && CS == 1'b0) begin
      tr0.push_back(MISO[0]);
      tr2.push_back(MISO[2]);
    end
    if (chg_at != 0 && nck == chg_at)
      cable_delay[2*DW +: DW] = chg_val;
  endtask

  task automatic frame(input logic [31:0] cmd, input int nb);
    int e0;
    e0  = errpulses;
    nck = 0;
    CS  = 1'b0;
    repeat (8) tick();
    for (int j = 0; j < nb; j++) begin
      MOSI = (j < 32) ? cmd[31-j] : 1'b0;
      repeat (4) tick();
      if (j < 32)
        for (int p = 0; p < N; p++)
          cap[p][31-j] = MISO[p];
      SCLK = 1'b1;
      repeat (4) tick();
      SCLK = 1'b0;
    end
    repeat (4) tick();
    CS   = 1'b1;
    MOSI = 1'b0;
    repeat (12) tick();
    fr_err = errpulses - e0;
  endtask

  task automatic cmp_shift(input string nm, input int d);
    int bad;
    int ones;
    bad  = 0;
    ones = 0;
    for (int t = d; t < tr0.size(); t++) begin
      if (tr2[t] !== tr0[t-d]) bad++;
      if (tr0[t-d] === 1'b1) ones++;
    end
    chk({nm, " mismatches"}, 32'(bad), 32'd0);
    chk({nm, " activity"}, 32'(ones > 0), 32'd1);
  endtask

  // Behavioural model: per-port LFSR value and a queue of pending replies.
  logic [15:0] mlfsr [N];
  logic [31:0] mq [N][$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] s;
    s = x / 16'd2;
    if (x % 16'd2 == 16'd1) s = s ^ 16'hB400;
    return s;
  endfunction

  function automatic logic [31:0] mresp(input int p, input logic [31:0] c,
                                        input int nb);
    logic [15:0] v;
    if (nb != 32) return 32'h0;
    case (c[31:30])
      2'b00: begin
        mlfsr[p] = lfsr_step(mlfsr[p]);
        return {mlfsr[p], 10'd0, c[21:16]};
      end
      2'b11: begin
        case (c[23:16])
          8'd251:  v = 16'h494E;
          8'd252:  v = 16'h5441;
          8'd253:  v = 16'h4E00;
          8'd255:  v = 16'h0020;
          default: v = 16'h0000;
        endcase
        return {16'h0000, v};
      end
      2'b10:   return {16'hFFFF, c[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] cmd;
    int          nb;
    logic        exp_err;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t tv [19];

  initial begin
    tv[0]  = '{32'h0005_0000, 32, 1'b0, 32'h0, 32'h0};
    tv[1]  = '{32'h0005_0000, 32, 1'b0, 32'h0, 32'h0};
    tv[2]  = '{32'h0005_0000, 32, 1'b0, 32'h0400_0005, 32'h0408_0005};
    tv[3]  = '{32'hC0FB_0000, 32, 1'b0, 32'h0200_0005, 32'h0204_0005};
    tv[4]  = '{32'hC0FC_0000, 32, 1'b0, 32'h0100_0005, 32'h0102_0005};
    tv[5]  = '{32'hC0FD_0000, 32, 1'b0, 32'h0000_494E, 32'h0000_494E};
    tv[6]  = '{32'hC0FF_0000, 32, 1'b0, 32'h0000_5441, 32'h0000_5441};
    tv[7]  = '{32'h4000_0000, 32, 1'b0, 32'h0000_4E00, 32'h0000_4E00};
    tv[8]  = '{32'h4000_0000, 32, 1'b0, 32'h0000_0020, 32'h0000_0020};
    tv[9]  = '{32'h8000_A5C3, 32, 1'b0, 32'h0, 32'h0};
    tv[10] = '{32'h4000_0000, 32, 1'b0, 32'h0, 32'h0};
    tv[11] = '{32'h0005_0000, 32, 1'b0, 32'hFFFF_A5C3, 32'hFFFF_A5C3};
    tv[12] = '{32'h4000_0000, 32, 1'b0, 32'h0, 32'h0};
    tv[13] = '{32'h4000_0000, 32, 1'b0, 32'h0080_0005, 32'h0081_0005};
    tv[14] = '{32'h0005_0000, 31, 1'b1, 32'h0, 32'h0};
    tv[15] = '{32'h4000_0000, 33, 1'b1, 32'h0, 32'h0};
    tv[16] = '{32'h0005_0000, 32, 1'b0, 32'h0, 32'h0};
    tv[17] = '{32'h4000_0000, 32, 1'b0, 32'h0, 32'h0};
    tv[18] = '{32'h4000_0000, 32, 1'b0, 32'h0040_0005, 32'hB440_0005};

    rst = 1'b1; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    cable_delay = '0;
    repeat (3) @(negedge clk);
    chk("reset MISO", 32'(MISO), 32'h0);
    chk("reset frame_err", 32'(frame_err), 32'h0);
    chk("reset frame_count", 32'(frame_count), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      frame(tv[i].cmd, tv[i].nb);
      chk($sformatf("tv%0d err", i), 32'(fr_err), 32'(tv[i].exp_err));
      chk($sformatf("tv%0d count", i), 32'(frame_count), 32'(i + 1));
      if (tv[i].nb == 32) begin
        chk($sformatf("tv%0d port0", i), cap[0], tv[i].exp0);
        chk($sformatf("tv%0d port1", i), cap[1], tv[i].exp1);
      end
    end

    // Cable delay: ports carry identical READ data, port 2 is delayed.
    frame(32'hC0FB_0000, 32);
    frame(32'hC0FB_0000, 32);
    cable_delay = '0;
    cable_delay[2*DW +: DW] = 5'd7;
    chg_val = 5'd3;
    chg_at  = 60;
    rec_on  = 1'b1;
    frame(32'hC0FB_0000, 32);
    rec_on = 1'b0;
    chg_at = 0;
    cmp_shift("delay7", 7);
    tr0.delete();
    tr2.delete();
    cable_delay[2*DW +: DW] = 5'd20;
    rec_on = 1'b1;
    frame(32'h4000_0000, 32);
    rec_on = 1'b0;
    cmp_shift("delay20clamp", 15);
    cable_delay = '0;

    // Reset in the middle of a frame.
    begin
      int e0;
      CS = 1'b0;
      repeat (8) @(negedge clk);
      for (int j = 0; j < 5; j++) begin
        MOSI = 1'b1;
        repeat (4) @(negedge clk);
        SCLK = 1'b1;
        repeat (4) @(negedge clk);
        SCLK = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("midrst MISO", 32'(MISO), 32'h0);
      e0 = errpulses;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 5; j++) begin
        repeat (4) @(negedge clk);
        SCLK = 1'b1;
        repeat (4) @(negedge clk);
        SCLK = 1'b0;
      end
      repeat (4) @(negedge clk);
      CS   = 1'b1;
      MOSI = 1'b0;
      repeat (12) @(negedge clk);
      chk("midrst count", 32'(frame_count), 32'h0);
      chk("midrst err", 32'(errpulses - e0), 32'h0);
    end

    // Random frames against the model, starting from seeds.
    for (int p = 0; p < N; p++) begin
      mlfsr[p] = 16'(2048 + 16 * p);
      mq[p].delete();
      mq[p].push_back(32'h0);
      mq[p].push_back(32'h0);
    end
    begin
      int mcount;
      mcount = 0;
      for (int k = 0; k < 45; k++) begin
        logic [31:0] cmd;
        int nb;
        int pick;
        if (k < 3) begin
          cmd = 32'h0005_0000;
          nb  = 32;
        end else begin
          cmd = $urandom;
          cmd[31:30] = 2'($urandom_range(0, 3));
          pick = $urandom_range(0, 6);
          if (cmd[31:30] == 2'b11 && pick < 5)
            cmd[23:16] = 8'(251 + pick);
          nb = ($urandom_range(0, 9) == 0) ?
               (($urandom_range(0, 1) == 0) ? 31 : 33) : 32;
        end
        frame(cmd, nb);
        mcount++;
        for (int p = 0; p < N; p++) begin
          logic [31:0] expw;
          expw = mq[p].pop_front();
          mq[p].push_back(mresp(p, cmd, nb));
          if (nb == 32)
            chk($sformatf("rnd%0d port%0d", k, p), cap[p], expw);
        end
        chk($sformatf("rnd%0d count", k), 32'(frame_count),
            32'(16'(mcount)));
        chk($sformatf("rnd%0d err", k), 32'(fr_err), 32'(nb != 32));
        if (k == 2)
          chk("restart port0", cap[0], 32'h0400_0005);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
